// File: rtl/pipe_ctrl.sv
// Pipeline hazard/trap controller: stalls on bus waits, bubbles load-use hazards,
// redirects the PC on exceptions, interrupts and exception returns.
module pipe_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_busy,
   input  logic        mem_busy,
   input  logic        ld_hazard,
   input  logic        mem_en,
   input  logic [29:0] mem_pc,
   input  logic [2:0]  mem_exp_code,
   input  logic        mem_eret,
   input  logic        int_req,
   input  logic [29:0] exp_vector,
   output logic        if_stall,
   output logic        id_stall,
   output logic        ex_stall,
   output logic        mem_stall,
   output logic        if_flush,
   output logic        id_flush,
   output logic        ex_flush,
   output logic        mem_flush,
   output logic [29:0] new_pc,
   output logic        pc_load,
   output logic [29:0] epc,
   output logic [2:0]  exp_code,
   output logic        int_en
);

   typedef enum logic {RUN, REFILL} state_t;

   state_t      state_q, state_d;
   logic [29:0] epc_q, epc_d;
   logic [2:0]  exp_code_q, exp_code_d;
   logic        int_en_q, int_en_d;
   logic        saved_int_en_q, saved_int_en_d;
   logic        busy;

   assign busy = if_busy | mem_busy;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= RUN;
         epc_q          <= '0;
         exp_code_q     <= '0;
         int_en_q       <= 1'b0;
         saved_int_en_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         epc_q          <= epc_d;
         exp_code_q     <= exp_code_d;
         int_en_q       <= int_en_d;
         saved_int_en_q <= saved_int_en_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      epc_d          = epc_q;
      exp_code_d     = exp_code_q;
      int_en_d       = int_en_q;
      saved_int_en_d = saved_int_en_q;
      if_stall       = 1'b0;
      id_stall       = 1'b0;
      ex_stall       = 1'b0;
      mem_stall      = 1'b0;
      if_flush       = 1'b0;
      id_flush       = 1'b0;
      ex_flush       = 1'b0;
      mem_flush      = 1'b0;
      pc_load        = 1'b0;
      new_pc         = '0;

      // Reset silences every control output; the register reset is in the ff.
      if (!reset) begin
         state_d = RUN;
      end else if (busy) begin
         if_stall  = 1'b1;
         id_stall  = 1'b1;
         ex_stall  = 1'b1;
         mem_stall = 1'b1;
      end else begin
         unique case (state_q)
            RUN: begin
               if (mem_en && (mem_exp_code != 3'd0)) begin
                  {if_flush, id_flush, ex_flush, mem_flush} = '1;
                  pc_load        = 1'b1;
                  new_pc         = exp_vector;
                  epc_d          = mem_pc;
                  exp_code_d     = mem_exp_code;
                  saved_int_en_d = int_en_q;
                  int_en_d       = 1'b0;
                  state_d        = REFILL;
               end else if (mem_en && mem_eret) begin
                  {if_flush, id_flush, ex_flush, mem_flush} = '1;
                  pc_load  = 1'b1;
                  new_pc   = epc_q;
                  int_en_d = saved_int_en_q;
                  state_d  = REFILL;
               end else if (mem_en && int_req && int_en_q) begin
                  {if_flush, id_flush, ex_flush, mem_flush} = '1;
                  pc_load        = 1'b1;
                  new_pc         = exp_vector;
                  epc_d          = mem_pc;
                  exp_code_d     = 3'd1;
                  saved_int_en_d = int_en_q;
                  int_en_d       = 1'b0;
                  state_d        = REFILL;
               end else if (ld_hazard) begin
                  if_stall = 1'b1;
                  id_flush = 1'b1;
               end
            end
            REFILL: state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   assign epc      = epc_q;
   assign exp_code = exp_code_q;
   assign int_en   = int_en_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: inputs change on the falling edge, outputs are
// checked 1 ns later; registered results appear after the following rising edge.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        reset, if_busy, mem_busy, ld_hazard, mem_en, mem_eret, int_req;
   logic [29:0] mem_pc, exp_vector, new_pc, epc;
   logic [2:0]  mem_exp_code, exp_code;
   logic        if_stall, id_stall, ex_stall, mem_stall;
   logic        if_flush, id_flush, ex_flush, mem_flush;
   logic        pc_load, int_en;

   int checks = 0;
   int errors = 0;

   localparam logic [29:0] VEC = 30'h2000;

   pipe_ctrl dut (
      .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
      .ld_hazard(ld_hazard), .mem_en(mem_en), .mem_pc(mem_pc),
      .mem_exp_code(mem_exp_code), .mem_eret(mem_eret), .int_req(int_req),
      .exp_vector(exp_vector),
      .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
      .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
      .new_pc(new_pc), .pc_load(pc_load), .epc(epc), .exp_code(exp_code), .int_en(int_en)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic [3:0] st, input logic [3:0] fl,
                          input logic pl, input logic [29:0] npc);
      chk({tag, "_stall"}, {28'd0, if_stall, id_stall, ex_stall, mem_stall}, {28'd0, st});
      chk({tag, "_flush"}, {28'd0, if_flush, id_flush, ex_flush, mem_flush}, {28'd0, fl});
      chk({tag, "_pcload"}, {31'd0, pc_load}, {31'd0, pl});
      chk({tag, "_newpc"}, {2'd0, new_pc}, {2'd0, npc});
   endtask

   task automatic chk_regs(input string tag, input logic [29:0] e, input logic [2:0] c,
                           input logic ie);
      chk({tag, "_epc"}, {2'd0, epc}, {2'd0, e});
      chk({tag, "_code"}, {29'd0, exp_code}, {29'd0, c});
      chk({tag, "_inten"}, {31'd0, int_en}, {31'd0, ie});
   endtask

   task automatic idle();
      if_busy = 0; mem_busy = 0; ld_hazard = 0; mem_en = 0; mem_pc = '0;
      mem_exp_code = '0; mem_eret = 0; int_req = 0;
   endtask

   initial begin
      exp_vector = VEC;
      reset = 0;
      idle();

      // Reset with noisy inputs: controls must stay quiet.
      @(negedge clk); ld_hazard = 1; if_busy = 1; mem_en = 1; mem_exp_code = 3'd2; #1;
      chk_ctl("rst_noise", 4'b0000, 4'b0000, 0, '0);
      @(negedge clk); idle(); #1;
      chk_regs("rst", '0, 3'd0, 0);
      @(negedge clk); reset = 1; #1;
      chk_ctl("idle", 4'b0000, 4'b0000, 0, '0);
      chk_regs("idle", '0, 3'd0, 0);

      // Load-use hazard for one cycle.
      @(negedge clk); ld_hazard = 1; #1;
      chk_ctl("ldu", 4'b1000, 4'b0100, 0, '0);
      @(negedge clk); ld_hazard = 0; #1;
      chk_ctl("ldu_end", 4'b0000, 4'b0000, 0, '0);

      // Exception held off by a data bus wait.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); mem_en = 1; mem_exp_code = 3'd2; mem_pc = 30'h100; mem_busy = 1; #1;
         chk_ctl("exc_busy", 4'b1111, 4'b0000, 0, '0);
         chk_regs("exc_busy", '0, 3'd0, 0);
      end
      @(negedge clk); mem_busy = 0; #1;
      chk_ctl("exc_take", 4'b0000, 4'b1111, 1, VEC);
      @(negedge clk); #1;
      chk_ctl("exc_refill", 4'b0000, 4'b0000, 0, '0);
      chk_regs("exc_refill", 30'h100, 3'd2, 0);
      @(negedge clk); idle(); ld_hazard = 1; #1;
      chk_ctl("exc_run", 4'b1000, 4'b0100, 0, '0);

      // Priority: exception beats eret, interrupt and load-use.
      @(negedge clk); idle(); mem_en = 1; mem_exp_code = 3'd3; mem_eret = 1;
      ld_hazard = 1; int_req = 1; mem_pc = 30'h55; #1;
      chk_ctl("prio", 4'b0000, 4'b1111, 1, VEC);
      @(negedge clk); #1;
      chk_ctl("prio_refill", 4'b0000, 4'b0000, 0, '0);
      chk_regs("prio_refill", 30'h55, 3'd3, 0);
      @(negedge clk); idle(); #1;
      chk_ctl("prio_run", 4'b0000, 4'b0000, 0, '0);

      // Busy during REFILL keeps REFILL for one more non-busy cycle.
      @(negedge clk); mem_en = 1; mem_eret = 1; #1;
      chk_ctl("eret1", 4'b0000, 4'b1111, 1, 30'h55);
      @(negedge clk); mem_eret = 0; mem_en = 0; if_busy = 1; #1;
      chk_ctl("refill_busy", 4'b1111, 4'b0000, 0, '0);
      @(negedge clk); if_busy = 0; mem_en = 1; mem_exp_code = 3'd6; #1;
      chk_ctl("refill_held", 4'b0000, 4'b0000, 0, '0);
      @(negedge clk); idle(); #1;
      chk_regs("refill_held", 30'h55, 3'd3, 0);

      // Interrupt round trip with int_en forced through the bench hook.
      force dut.int_en_q = 1'b1;
      @(posedge clk); #1;
      release dut.int_en_q;
      @(negedge clk); #1;
      chk("hook_inten", {31'd0, int_en}, 32'd1);
      @(negedge clk); mem_en = 1; int_req = 1; mem_pc = 30'h40; #1;
      chk_ctl("irq", 4'b0000, 4'b1111, 1, VEC);
      @(negedge clk); idle(); #1;
      chk_regs("irq_refill", 30'h40, 3'd1, 0);
      @(negedge clk); mem_en = 1; int_req = 1; mem_pc = 30'h99; #1;
      chk_ctl("irq_masked", 4'b0000, 4'b0000, 0, '0);
      @(negedge clk); idle(); mem_en = 1; mem_eret = 1; #1;
      chk_ctl("eret2", 4'b0000, 4'b1111, 1, 30'h40);
      @(negedge clk); idle(); #1;
      chk_regs("eret2_refill", 30'h40, 3'd1, 1);

      // Reset asserted during REFILL.
      @(negedge clk); mem_en = 1; mem_exp_code = 3'd5; mem_pc = 30'h77; #1;
      chk_ctl("exc5", 4'b0000, 4'b1111, 1, VEC);
      @(negedge clk); reset = 0; #1;
      chk_ctl("rst_refill", 4'b0000, 4'b0000, 0, '0);
      chk_regs("rst_refill_pre", 30'h77, 3'd5, 0);
      @(negedge clk); reset = 1; idle(); #1;
      chk_ctl("rst_after", 4'b0000, 4'b0000, 0, '0);
      chk_regs("rst_after", '0, 3'd0, 0);
      @(negedge clk); mem_en = 1; mem_exp_code = 3'd4; mem_pc = 30'h12; #1;
      chk_ctl("rst_run", 4'b0000, 4'b1111, 1, VEC);
      @(negedge clk); idle(); #1;
      chk_regs("rst_run", 30'h12, 3'd4, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
